// File: rtl/atmega_spi_s_if.sv
// atmega_spi_s_if: IO register bus between the ATmega core and the SPI slave.
interface atmega_spi_s_if #(parameter int BUS_ADDR_IO_LEN = 6);
    logic [BUS_ADDR_IO_LEN-1:0] addr;
    logic                       wr;
    logic                       rd;
    logic [7:0]                 bus_in;
    logic [7:0]                 bus_out;
    logic                       irq;
    logic                       int_rst;
    modport master (output addr, wr, rd, bus_in, int_rst, input bus_out, irq);
    modport slave  (input addr, wr, rd, bus_in, int_rst, output bus_out, irq);
endinterface

// File: rtl/atmega_spi_s.sv
// atmega_spi_s: SPI slave (CPHA=0) on the SPCR/SPSR/SPDR IO bus.
// Define ATMEGA_SPI_S_RX_BUF_EN for a one-deep RX holding buffer with overrun flag.
module atmega_spi_s #(
    parameter int BUS_ADDR_IO_LEN = 6,
    parameter int SPCR_ADDR       = 0,
    parameter int SPSR_ADDR       = 1,
    parameter int SPDR_ADDR       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    atmega_spi_s_if.slave        bus,
    output logic                 io_connect_o,
    input  logic                 ss_n_i,
    input  logic                 sck_i,
    input  logic                 mosi_i,
    output logic                 miso_o,
    output logic                 miso_oe_o
);
    localparam logic [BUS_ADDR_IO_LEN-1:0] A_SPCR = BUS_ADDR_IO_LEN'(SPCR_ADDR);
    localparam logic [BUS_ADDR_IO_LEN-1:0] A_SPSR = BUS_ADDR_IO_LEN'(SPSR_ADDR);
    localparam logic [BUS_ADDR_IO_LEN-1:0] A_SPDR = BUS_ADDR_IO_LEN'(SPDR_ADDR);

    logic [1:0] ss_q, mosi_q;
    logic [2:0] sck_q, bit_cnt_q;
    logic [7:0] spcr_q, rx_data_q, rx_shift_q, tx_shift_q, tx_hold_q, rx_shift_d, tx_shift_d;
    logic       spif_q, wcol_q, ovr_q, spsr0_q, rd_old_q, reload_q;
    logic       en, dord, cpol, active, rise, fall, lead, trail, done, spdr_wr, spdr_rd_fall, clr;
`ifdef ATMEGA_SPI_S_RX_BUF_EN
    logic [7:0] buf_q;
    logic       buf_full_q;
`endif

    always_comb begin
        en           = spcr_q[6];
        dord         = spcr_q[5];
        cpol         = spcr_q[3];
        active       = en & ~ss_q[1];
        rise         = sck_q[1] & ~sck_q[2];
        fall         = ~sck_q[1] & sck_q[2];
        lead         = active & (cpol ? fall : rise);
        trail        = active & (cpol ? rise : fall);
        done         = lead & (bit_cnt_q == 3'd7);
        rx_shift_d   = dord ? {mosi_q[1], rx_shift_q[7:1]} : {rx_shift_q[6:0], mosi_q[1]};
        tx_shift_d   = dord ? {1'b1, tx_shift_q[7:1]} : {tx_shift_q[6:0], 1'b1};
        spdr_wr      = bus.wr & (bus.addr == A_SPDR);
        spdr_rd_fall = rd_old_q & ~bus.rd & (bus.addr == A_SPDR);
        clr          = bus.int_rst | spdr_rd_fall;
        io_connect_o = en;
        miso_oe_o    = active;
        miso_o       = ~en | (dord ? tx_shift_q[0] : tx_shift_q[7]);
        bus.irq      = spif_q & spcr_q[7];
        bus.bus_out  = !bus.rd ? 8'h00 :
                       bus.addr == A_SPCR ? spcr_q :
                       bus.addr == A_SPSR ? {spif_q, wcol_q, ovr_q, 4'b0000, spsr0_q} :
                       bus.addr == A_SPDR ? rx_data_q : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q       <= 2'b11;
            sck_q      <= 3'b000;
            mosi_q     <= 2'b00;
            spcr_q     <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'hFF;
            tx_hold_q  <= 8'hFF;
            bit_cnt_q  <= 3'd0;
            spif_q     <= 1'b0;
            wcol_q     <= 1'b0;
            ovr_q      <= 1'b0;
            spsr0_q    <= 1'b0;
            rd_old_q   <= 1'b0;
            reload_q   <= 1'b0;
`ifdef ATMEGA_SPI_S_RX_BUF_EN
            buf_q      <= 8'h00;
            buf_full_q <= 1'b0;
`endif
        end else begin
            ss_q     <= {ss_q[0], ss_n_i};
            sck_q    <= {sck_q[1:0], sck_i};
            mosi_q   <= {mosi_q[0], mosi_i};
            rd_old_q <= bus.rd;
            if (bus.wr && bus.addr == A_SPCR) spcr_q <= bus.bus_in;
            if (bus.wr && bus.addr == A_SPSR) spsr0_q <= bus.bus_in[0];
            if (clr) begin
                spif_q <= 1'b0;
                wcol_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
`ifdef ATMEGA_SPI_S_RX_BUF_EN
            if (spdr_rd_fall && buf_full_q) begin
                rx_data_q  <= buf_q;
                buf_full_q <= 1'b0;
                spif_q     <= 1'b1;
            end
`endif
            if (!active) begin
                bit_cnt_q  <= 3'd0;
                rx_shift_q <= 8'h00;
                tx_shift_q <= tx_hold_q;
                reload_q   <= 1'b0;
            end else begin
                if (lead) begin
                    rx_shift_q <= rx_shift_d;
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                end
                if (done) begin
                    spif_q    <= 1'b1;
                    tx_hold_q <= 8'hFF;
                    reload_q  <= 1'b1;
`ifdef ATMEGA_SPI_S_RX_BUF_EN
                    if (!spif_q) rx_data_q <= rx_shift_d;
                    else if (!buf_full_q) begin
                        buf_q      <= rx_shift_d;
                        buf_full_q <= 1'b1;
                    end else ovr_q <= 1'b1;
`else
                    rx_data_q <= rx_shift_d;
`endif
                end
                if (trail) begin
                    tx_shift_q <= reload_q ? tx_hold_q : tx_shift_d;
                    reload_q   <= 1'b0;
                end
            end
            // A write is only accepted between bytes; otherwise it collides.
            if (spdr_wr) begin
                if (bit_cnt_q == 3'd0) begin
                    tx_hold_q  <= bus.bus_in;
                    tx_shift_q <= bus.bus_in;
                end else wcol_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_atmega_spi_s.sv
// tb_atmega_spi_s: directed SPI master transfers against the slave with hand-computed results.
module tb_atmega_spi_s;
    logic clk = 1'b0, rst = 1'b1;
    logic io_connect, ss_n = 1'b1, sck = 1'b0, mosi = 1'b0, miso, miso_oe;
    logic [7:0] d, rx;
    int checks = 0, failures = 0;

    atmega_spi_s_if #(.BUS_ADDR_IO_LEN(6)) bus ();

    atmega_spi_s dut (
        .clk(clk), .rst(rst), .bus(bus), .io_connect_o(io_connect),
        .ss_n_i(ss_n), .sck_i(sck), .mosi_i(mosi), .miso_o(miso), .miso_oe_o(miso_oe)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [7:0] v);
        bus.addr = a; bus.bus_in = v; bus.wr = 1'b1;
        tick(1);
        bus.wr = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [7:0] v);
        bus.addr = a; bus.rd = 1'b1;
        tick(1);
        v = bus.bus_out;
        bus.rd = 1'b0;
        tick(1);
    endtask

    // hook 1: SPDR write right after the 2nd leading edge; hook 2: int_rst on the completing cycle
    task automatic xfer(input logic [7:0] tx, input logic lsb, input logic cpol, input int nbits,
                        input int hook, input logic keep_ss, output logic [7:0] r);
        r = 8'h00;
        ss_n = 1'b0;
        tick(5);
        for (int i = 0; i < nbits; i++) begin
            mosi = lsb ? tx[i] : tx[7-i];
            tick(5);
            r = lsb ? {miso, r[7:1]} : {r[6:0], miso};
            sck = ~cpol;
            if (hook == 1 && i == 1) begin
                bus_write(6'd2, 8'h00);
                tick(4);
            end else if (hook == 2 && i == 7) begin
                tick(2);
                bus.int_rst = 1'b1;
                tick(1);
                bus.int_rst = 1'b0;
                tick(2);
            end else tick(5);
            sck = cpol;
        end
        tick(5);
        if (!keep_ss) begin
            ss_n = 1'b1;
            tick(5);
        end
    endtask

    initial begin
        bus.addr = '0; bus.wr = 1'b0; bus.rd = 1'b0; bus.bus_in = 8'h00; bus.int_rst = 1'b0;
        tick(3);
        check("rst_miso", {7'b0, miso}, 8'h01);
        check("rst_oe", {7'b0, miso_oe}, 8'h00);
        check("rst_int", {7'b0, bus.irq}, 8'h00);
        rst = 1'b0;
        tick(1);
        check("rst_busout_idle", bus.bus_out, 8'h00);
        bus_read(6'd0, d); check("rst_spcr", d, 8'h00);
        bus_read(6'd1, d); check("rst_spsr", d, 8'h00);
        bus_read(6'd2, d); check("rst_spdr", d, 8'h00);

        bus_write(6'd0, 8'h40);
        check("t1_io_connect", {7'b0, io_connect}, 8'h01);
        bus_write(6'd2, 8'hA5);
        xfer(8'h3C, 1'b0, 1'b0, 8, 0, 1'b0, rx);
        check("t1_master_rx", rx, 8'hA5);
        bus_read(6'd1, d); check("t1_spsr", d, 8'h80);
        check("t1_int_off", {7'b0, bus.irq}, 8'h00);
        bus_write(6'd0, 8'hC0);
        check("t1_int_on", {7'b0, bus.irq}, 8'h01);
        bus_read(6'd2, d); check("t1_spdr", d, 8'h3C);
        bus_read(6'd1, d); check("t1_spsr_clr", d, 8'h00);
        check("t1_int_clr", {7'b0, bus.irq}, 8'h00);

        sck = 1'b1;
        bus_write(6'd0, 8'h68);
        bus_write(6'd2, 8'h0F);
        xfer(8'h81, 1'b1, 1'b1, 8, 0, 1'b0, rx);
        check("t2_master_rx", rx, 8'h0F);
        bus_read(6'd2, d); check("t2_spdr", d, 8'h81);

        bus_write(6'd0, 8'h40);
        sck = 1'b0;
        tick(5);
        bus_write(6'd2, 8'hC3);
        xfer(8'h5A, 1'b0, 1'b0, 8, 1, 1'b0, rx);
        check("t3_master_rx", rx, 8'hC3);
        bus_read(6'd1, d); check("t3_spsr_wcol", d, 8'hC0);
        bus_read(6'd2, d); check("t3_spdr", d, 8'h5A);
        bus_read(6'd1, d); check("t3_spsr_clr", d, 8'h00);

        bus_write(6'd2, 8'h96);
        xfer(8'hFF, 1'b0, 1'b0, 5, 0, 1'b0, rx);
        bus_read(6'd1, d); check("t4_no_spif", d, 8'h00);
        xfer(8'h55, 1'b0, 1'b0, 8, 0, 1'b0, rx);
        check("t4_master_rx", rx, 8'h96);
        bus_read(6'd1, d); check("t4_spsr", d, 8'h80);
        bus_read(6'd2, d); check("t4_spdr", d, 8'h55);

        xfer(8'h6B, 1'b0, 1'b0, 8, 2, 1'b0, rx);
        bus_read(6'd1, d); check("t5_set_wins", d, 8'h80);
        bus.int_rst = 1'b1;
        tick(1);
        bus.int_rst = 1'b0;
        bus_read(6'd1, d); check("t5_int_rst_clr", d, 8'h00);
        bus_read(6'd2, d); check("t5_spdr", d, 8'h6B);

        xfer(8'h11, 1'b0, 1'b0, 8, 0, 1'b0, rx);
        xfer(8'h22, 1'b0, 1'b0, 8, 0, 1'b0, rx);
        xfer(8'h33, 1'b0, 1'b0, 8, 0, 1'b0, rx);
`ifdef ATMEGA_SPI_S_RX_BUF_EN
        bus_read(6'd1, d); check("t6_spsr_ovr", d, 8'hA0);
        bus_read(6'd2, d); check("t6_rd1", d, 8'h11);
        bus_read(6'd1, d); check("t6_spif_kept", d, 8'h80);
        bus_read(6'd2, d); check("t6_rd2", d, 8'h22);
`else
        bus_read(6'd1, d); check("t6_spsr", d, 8'h80);
        bus_read(6'd2, d); check("t6_rd", d, 8'h33);
`endif
        bus_read(6'd1, d); check("t6_spsr_clr", d, 8'h00);

        bus_write(6'd0, 8'hC0);
        xfer(8'h01, 1'b0, 1'b0, 8, 0, 1'b0, rx);
        check("t7_int_pre", {7'b0, bus.irq}, 8'h01);
        bus_write(6'd2, 8'h00);
        xfer(8'hF0, 1'b0, 1'b0, 3, 0, 1'b1, rx);
        check("t7_oe_pre", {7'b0, miso_oe}, 8'h01);
        check("t7_miso_pre", {7'b0, miso}, 8'h00);
        rst = 1'b1;
        tick(1);
        check("t7_miso", {7'b0, miso}, 8'h01);
        check("t7_oe", {7'b0, miso_oe}, 8'h00);
        check("t7_int", {7'b0, bus.irq}, 8'h00);
        check("t7_io_connect", {7'b0, io_connect}, 8'h00);
        ss_n = 1'b1; sck = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        bus_read(6'd0, d); check("t7_spcr", d, 8'h00);
        bus_read(6'd1, d); check("t7_spsr", d, 8'h00);
        bus_read(6'd2, d); check("t7_spdr", d, 8'h00);
        bus_write(6'd0, 8'h40);
        bus_write(6'd2, 8'h3A);
        xfer(8'hC7, 1'b0, 1'b0, 8, 0, 1'b0, rx);
        check("t7_master_rx", rx, 8'h3A);
        bus_read(6'd1, d); check("t7_spsr_after", d, 8'h80);
        bus_read(6'd2, d); check("t7_spdr_after", d, 8'hC7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
